jtsdram_scrambler: RTL

// - Parametrised, pipelined address/data scrambler between the test-pattern generator and the SDRAM controller.
// - Write path: scrambles each request's address and data under a runtime key, with a valid/ready handshake.
// - Read-return path: applies the exact inverse data transform so the checker sees the original data.
// - The key is reloaded at run time; a reload waits until both pipelines are empty.

---
 rtl/jtsdram_scrambler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/jtsdram_scrambler.sv
// rtl/jtsdram_scrambler.sv - keyed address/data scrambler with inverse read-return path.
// Optional write-side self-check is built when JTSDRAM_SCRAMBLER_CHK_EN is defined.
module jtsdram_scrambler #(
    parameter int AW = 22,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [4:0]    key_in_i,
    input  logic          key_we_i,
    output logic          key_busy_o,
    output logic [4:0]    key_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_prog_i,
    input  logic [AW-1:0] in_addr_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_addr_o,
    output logic [DW-1:0] out_data_o,
    input  logic          rd_valid_i,
    input  logic          rd_prog_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          rdo_valid_o,
    output logic [DW-1:0] rdo_data_o,
    output logic          chk_err_o
);
    localparam int H  = AW / 2;
    localparam int NL = H / 4;
    localparam int NH = (AW - H) / 4;
    localparam int HD = DW / 2;
    localparam int ND = HD / 4;

    typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

    function automatic logic [3:0] swap4(input logic [3:0] a);
        return {a[2], a[0], a[3], a[1]};
    endfunction

    function automatic logic [3:0] iswap4(input logic [3:0] a);
        return {a[1], a[3], a[0], a[2]};
    endfunction

    function automatic logic [AW-1:0] alt_a(input logic lsb);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = lsb ^ i[0];
        return r;
    endfunction

    function automatic logic [DW-1:0] alt_d(input logic lsb);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = lsb ^ i[0];
        return r;
    endfunction

    localparam logic [AW-1:0] A5 = alt_a(1'b1);
    localparam logic [AW-1:0] AA = alt_a(1'b0);
    localparam logic [DW-1:0] D5 = alt_d(1'b1);
    localparam logic [DW-1:0] DA = alt_d(1'b0);

    function automatic logic [AW-1:0] addr_fwd(input logic [AW-1:0] a, input logic [4:0] k);
        logic [AW-1:0] r;
        r = a;
        if (k[0]) r = (r << H) | (r >> (AW - H));
        if (k[1]) for (int i = 0; i < NL; i++) r[i*4 +: 4] = swap4(r[i*4 +: 4]);
        if (k[2]) for (int i = 0; i < NH; i++) r[H+i*4 +: 4] = swap4(r[H+i*4 +: 4]);
        if (k[3]) r = r ^ A5;
        if (k[4]) r = r ^ AA;
        return r;
    endfunction

    // Only the low nibble of the recovered plain address is needed on the read side.
    function automatic logic [3:0] addr_inv_lo(input logic [AW-1:0] a, input logic [4:0] k);
        logic [AW-1:0] r;
        r = a;
        if (k[4]) r = r ^ AA;
        if (k[3]) r = r ^ A5;
        if (k[2]) for (int i = 0; i < NH; i++) r[H+i*4 +: 4] = iswap4(r[H+i*4 +: 4]);
        if (k[1]) for (int i = 0; i < NL; i++) r[i*4 +: 4] = iswap4(r[i*4 +: 4]);
        if (k[0]) r = (r >> H) | (r << (AW - H));
        return r[3:0];
    endfunction

    function automatic logic [DW-1:0] data_fwd(input logic [DW-1:0] d, input logic [3:0] s,
                                              input logic k4);
        logic [DW-1:0] r;
        r = d;
        if (s[0]) r = {r[HD-1:0], r[DW-1:HD]};
        if (s[1]) for (int i = 0; i < ND; i++) r[i*4 +: 4] = swap4(r[i*4 +: 4]);
        if (s[2]) for (int i = 0; i < ND; i++) r[HD+i*4 +: 4] = swap4(r[HD+i*4 +: 4]);
        if (s[3]) r = r ^ D5;
        if (k4)   r = r ^ DA;
        return r;
    endfunction

    function automatic logic [DW-1:0] data_inv(input logic [DW-1:0] d, input logic [3:0] s,
                                              input logic k4);
        logic [DW-1:0] r;
        r = d;
        if (k4)   r = r ^ DA;
        if (s[3]) r = r ^ D5;
        if (s[2]) for (int i = 0; i < ND; i++) r[HD+i*4 +: 4] = iswap4(r[HD+i*4 +: 4]);
        if (s[1]) for (int i = 0; i < ND; i++) r[i*4 +: 4] = iswap4(r[i*4 +: 4]);
        if (s[0]) r = {r[HD-1:0], r[DW-1:HD]};
        return r;
    endfunction

    state_t        state_q;
    logic [4:0]    key_q, pend_q;
    logic          out_valid_q, rdo_valid_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_data_q, rdo_data_q;

    logic          accept_d;
    logic [AW-1:0] wr_addr_d;
    logic [3:0]    wr_e_d, rd_e_d;
    logic [DW-1:0] wr_data_d, rd_data_d;

    assign key_busy_o = (state_q != RUN);
    assign in_ready_o = ~key_busy_o & (~out_valid_q | out_ready_i);
    assign accept_d   = in_valid_i & in_ready_o;

    assign wr_addr_d = addr_fwd(in_addr_i, key_q);
    assign wr_e_d    = in_prog_i ? in_addr_i[3:0] : wr_addr_d[3:0];
    assign wr_data_d = data_fwd(in_data_i, key_q[3:0] ^ wr_e_d, key_q[4]);

    assign rd_e_d    = rd_prog_i ? addr_inv_lo(rd_addr_i, key_q) : rd_addr_i[3:0];
    assign rd_data_d = data_inv(rd_data_i, key_q[3:0] ^ rd_e_d, key_q[4]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            key_q       <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            rdo_valid_q <= 1'b0;
            rdo_data_q  <= '0;
        end else begin
            if (accept_d) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= wr_addr_d;
                out_data_q  <= wr_data_d;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            rdo_valid_q <= rd_valid_i;
            if (rd_valid_i) rdo_data_q <= rd_data_d;
            // A key written while busy replaces the pending one; in APPLY it goes straight in.
            case (state_q)
                RUN: if (key_we_i) begin
                    pend_q  <= key_in_i;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (key_we_i) pend_q <= key_in_i;
                    if (!out_valid_q && !rdo_valid_q) state_q <= APPLY;
                end
                APPLY: begin
                    key_q   <= key_we_i ? key_in_i : pend_q;
                    state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign key_o       = key_q;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;
    assign rdo_valid_o = rdo_valid_q;
    assign rdo_data_o  = rdo_data_q;

`ifdef JTSDRAM_SCRAMBLER_CHK_EN
    logic          chk_err_q;
    logic [DW-1:0] chk_data_d;

    assign chk_data_d = data_inv(wr_data_d, key_q[3:0] ^ wr_e_d, key_q[4]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chk_err_q <= 1'b0;
        end else if (accept_d && (chk_data_d != in_data_i)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err_o = chk_err_q;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule
